// File: rtl/batch_sign_lut_pkg.sv
// -----------------------------------------------------------------------------
// batch_sign_lut_pkg
// Shared estimation-filter definitions:
//   FRAC_W_DEF       default number of fractional coefficient bits
//   cword_t / cplx_t wide signed fixed-point component and complex pair; every
//                    narrower component fits losslessly, so one type serves all
//                    parameterisations
//   word_sign_term   sign-extend a component from bit w-1, negate if !pos
//   cplx_sign_term   the same operation applied to a complex pair
// -----------------------------------------------------------------------------
package batch_sign_lut_pkg;

   localparam int FRAC_W_DEF = 14;
   localparam int CPLX_W     = 32;

   typedef logic signed [CPLX_W-1:0] cword_t;

   typedef struct packed {
      cword_t re;
      cword_t im;
   } cplx_t;

   // The shift pair sign-extends from bit w-1. Negation happens at full width,
   // so negating the most negative w-bit value is exact.
   function automatic cword_t word_sign_term(input cword_t x, input int w, input logic pos);
      cword_t ext;
      ext = (x <<< (CPLX_W - w)) >>> (CPLX_W - w);
      if (pos) begin
         word_sign_term = ext;
      end else begin
         word_sign_term = -ext;
      end
   endfunction

   function automatic cplx_t cplx_sign_term(input cplx_t c, input int w, input logic pos);
      cplx_t r;
      r.re = word_sign_term(c.re, w, pos);
      r.im = word_sign_term(c.im, w, pos);
      return r;
   endfunction

endpackage

// File: rtl/batch_sign_lut_if.sv
// -----------------------------------------------------------------------------
// batch_sign_lut_if
// Bundles the sample path, the coefficient config port and the result port.
//   in_valid, sel                       sample strobe + M control bits
//   cfg_we, cfg_addr, cfg_re, cfg_im    shadow-bank write
//   cfg_commit                          shadow -> active copy
//   out_valid, out_re, out_im           signed complex sum
// master: the producer of samples/config; slave: batch_sign_lut itself.
// -----------------------------------------------------------------------------
interface batch_sign_lut_if #(
   parameter int M      = 4,
   parameter int DATA_W = 16,
   parameter int OUT_W  = DATA_W + $clog2(M) + 1
);
   localparam int AW = (M > 1) ? $clog2(M) : 1;

   logic                     in_valid;
   logic [M-1:0]             sel;
   logic                     cfg_we;
   logic [AW-1:0]            cfg_addr;
   logic signed [DATA_W-1:0] cfg_re;
   logic signed [DATA_W-1:0] cfg_im;
   logic                     cfg_commit;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_re;
   logic signed [OUT_W-1:0]  out_im;

   modport master (
      output in_valid, sel, cfg_we, cfg_addr, cfg_re, cfg_im, cfg_commit,
      input  out_valid, out_re, out_im
   );

   modport slave (
      input  in_valid, sel, cfg_we, cfg_addr, cfg_re, cfg_im, cfg_commit,
      output out_valid, out_re, out_im
   );

endinterface

// File: rtl/batch_sign_lut_complex_add_tree.sv
// -----------------------------------------------------------------------------
// complex_add_tree
// Pipelined binary adder tree over N complex operands, one register per level
// ($clog2(N) levels). An odd leftover operand at a level is registered unchanged
// so every operand of a sample arrives at the root on the same cycle. The valid
// bit travels alongside; a level only loads when its incoming valid is set, so
// the outputs hold the last valid result while out_valid_o is low.
// No width growth: the caller sizes IN_W to hold the full sum.
//   clk, rst_n            clock, async active-low reset
//   in_valid_i            operand strobe
//   in_re_i, in_im_i      N packed IN_W-bit operands (operand j at [j*IN_W +: IN_W])
//   out_valid_o           result strobe
//   out_re_o, out_im_o    IN_W-bit sums
// -----------------------------------------------------------------------------
module complex_add_tree
   import batch_sign_lut_pkg::*;
#(
   parameter int N    = 4,
   parameter int IN_W = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   input  logic [N*IN_W-1:0] in_re_i,
   input  logic [N*IN_W-1:0] in_im_i,
   output logic              out_valid_o,
   output logic [IN_W-1:0]   out_re_o,
   output logic [IN_W-1:0]   out_im_o
);

   localparam int D = $clog2(N);

   // Operand count present at level l (level 0 = tree inputs).
   function automatic int cnt_at(input int l);
      return (N + (1 << l) - 1) >> l;
   endfunction

   // Position of level l's first node in the flat register vector.
   function automatic int base_at(input int l);
      int b;
      b = 0;
      for (int k = 1; k < l; k++) begin
         b = b + cnt_at(k);
      end
      return b;
   endfunction

   localparam int TOT = base_at(D + 1);

   generate
      if (D == 0) begin : g_flat
         assign out_valid_o = in_valid_i;
         assign out_re_o    = in_re_i;
         assign out_im_o    = in_im_i;
      end else begin : g_tree
         logic [TOT*IN_W-1:0] re_q;
         logic [TOT*IN_W-1:0] im_q;
         logic [D-1:0]        vld_q;

         for (genvar l = 1; l <= D; l++) begin : g_lvl
            localparam int NIN  = cnt_at(l - 1);
            localparam int NOUT = cnt_at(l);
            localparam int BI   = base_at(l - 1);
            localparam int BO   = base_at(l);

            logic                vin_s;
            logic [NIN*IN_W-1:0] src_re_s;
            logic [NIN*IN_W-1:0] src_im_s;

            if (l == 1) begin : g_src_in
               assign vin_s    = in_valid_i;
               assign src_re_s = in_re_i;
               assign src_im_s = in_im_i;
            end else begin : g_src_prev
               assign vin_s    = vld_q[l-2];
               assign src_re_s = re_q[BI*IN_W +: NIN*IN_W];
               assign src_im_s = im_q[BI*IN_W +: NIN*IN_W];
            end

            // Valid bit for this level.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  vld_q[l-1] <= 1'b0;
               end else begin
                  vld_q[l-1] <= vin_s;
               end
            end

            for (genvar j = 0; j < NOUT; j++) begin : g_node
               if (2 * j + 1 < NIN) begin : g_add
                  // Pairwise sum, loaded only with a valid sample.
                  always_ff @(posedge clk or negedge rst_n) begin
                     if (!rst_n) begin
                        re_q[(BO+j)*IN_W +: IN_W] <= '0;
                        im_q[(BO+j)*IN_W +: IN_W] <= '0;
                     end else if (vin_s) begin
                        re_q[(BO+j)*IN_W +: IN_W] <= src_re_s[(2*j)*IN_W +: IN_W]
                                                   + src_re_s[(2*j+1)*IN_W +: IN_W];
                        im_q[(BO+j)*IN_W +: IN_W] <= src_im_s[(2*j)*IN_W +: IN_W]
                                                   + src_im_s[(2*j+1)*IN_W +: IN_W];
                     end
                  end
               end else begin : g_pass
                  // Odd leftover: delay by one level to stay aligned.
                  always_ff @(posedge clk or negedge rst_n) begin
                     if (!rst_n) begin
                        re_q[(BO+j)*IN_W +: IN_W] <= '0;
                        im_q[(BO+j)*IN_W +: IN_W] <= '0;
                     end else if (vin_s) begin
                        re_q[(BO+j)*IN_W +: IN_W] <= src_re_s[(2*j)*IN_W +: IN_W];
                        im_q[(BO+j)*IN_W +: IN_W] <= src_im_s[(2*j)*IN_W +: IN_W];
                     end
                  end
               end
            end
         end

         assign out_valid_o = vld_q[D-1];
         assign out_re_o    = re_q[(TOT-1)*IN_W +: IN_W];
         assign out_im_o    = im_q[(TOT-1)*IN_W +: IN_W];
      end
   endgenerate

endmodule

// File: rtl/batch_sign_lut.sv
// -----------------------------------------------------------------------------
// batch_sign_lut
// Per sample, sums sel[k] ? +c_k : -c_k over M complex coefficients. The
// coefficients are double-buffered: config writes land in a shadow bank and
// cfg_commit copies the whole shadow bank into the active bank that the data
// path reads. Latency is 1 + $clog2(M) cycles, one sample per clock.
//   clk, rst_n   clock, async active-low reset (clears banks and pipeline)
//   bus (slave)  sample in, config port, result out (see batch_sign_lut_if)
// -----------------------------------------------------------------------------
module batch_sign_lut
   import batch_sign_lut_pkg::*;
#(
   parameter int M      = 4,
   parameter int DATA_W = 16,
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int OUT_W  = DATA_W + $clog2(M) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   batch_sign_lut_if.slave   bus
);

   localparam int AW = (M > 1) ? $clog2(M) : 1;

   // A narrower OUT_W could wrap the sum, which the design never saturates.
   generate
      if ((M < 1) || (OUT_W < DATA_W + $clog2(M) + 1) || (FRAC_W >= DATA_W)) begin : g_bad_param
         $error("batch_sign_lut: illegal M/OUT_W/FRAC_W combination");
      end
   endgenerate

   logic signed [DATA_W-1:0] sh_re_q  [M];
   logic signed [DATA_W-1:0] sh_im_q  [M];
   logic signed [DATA_W-1:0] act_re_q [M];
   logic signed [DATA_W-1:0] act_im_q [M];
   logic signed [OUT_W-1:0]  term_re_q [M];
   logic signed [OUT_W-1:0]  term_im_q [M];
   logic [M*OUT_W-1:0]       leaf_re_s;
   logic [M*OUT_W-1:0]       leaf_im_s;
   logic                     vld0_q;

   generate
      for (genvar k = 0; k < M; k++) begin : g_coef
         localparam logic [AW-1:0] K_ADDR = AW'(k);

         // Coefficient banks. Commit reads the shadow value from before this
         // edge, so a write in the commit cycle needs a further commit.
         // Addresses >= M match no entry and are dropped.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sh_re_q[k]  <= '0;
               sh_im_q[k]  <= '0;
               act_re_q[k] <= '0;
               act_im_q[k] <= '0;
            end else begin
               if (bus.cfg_commit) begin
                  act_re_q[k] <= sh_re_q[k];
                  act_im_q[k] <= sh_im_q[k];
               end
               if (bus.cfg_we && (bus.cfg_addr == K_ADDR)) begin
                  sh_re_q[k] <= bus.cfg_re;
                  sh_im_q[k] <= bus.cfg_im;
               end
            end
         end

         // Sign stage: widen before negating so -(-2^(DATA_W-1)) is exact.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               term_re_q[k] <= '0;
               term_im_q[k] <= '0;
            end else if (bus.in_valid) begin
               term_re_q[k] <= OUT_W'(word_sign_term(cword_t'(act_re_q[k]), DATA_W, bus.sel[k]));
               term_im_q[k] <= OUT_W'(word_sign_term(cword_t'(act_im_q[k]), DATA_W, bus.sel[k]));
            end
         end

         assign leaf_re_s[k*OUT_W +: OUT_W] = term_re_q[k];
         assign leaf_im_s[k*OUT_W +: OUT_W] = term_im_q[k];
      end
   endgenerate

   // Valid bit of the sign stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0_q <= 1'b0;
      end else begin
         vld0_q <= bus.in_valid;
      end
   end

   complex_add_tree #(
      .N    (M),
      .IN_W (OUT_W)
   ) u_tree (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (vld0_q),
      .in_re_i     (leaf_re_s),
      .in_im_i     (leaf_im_s),
      .out_valid_o (bus.out_valid),
      .out_re_o    (bus.out_re),
      .out_im_o    (bus.out_im)
   );

endmodule

// File: tb/tb_batch_sign_lut.sv
module tb_batch_sign_lut;

   localparam int M      = 4;
   localparam int DATA_W = 16;
   localparam int OUT_W  = 19;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   batch_sign_lut_if #(.M(M), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

   batch_sign_lut #(.M(M), .DATA_W(DATA_W), .FRAC_W(14), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int sh_re[4], sh_im[4], act_re[4], act_im[4];
   bit p0_v, p1_v, e_v;
   int p0_re, p0_im, p1_re, p1_im, e_re, e_im;

   function automatic int lut_sum(input logic [3:0] s, input int c[4]);
      int acc;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         if (s[k]) acc += c[k];
         else      acc -= c[k];
      end
      return acc;
   endfunction

   // Result computed at sample time, delayed 3 cycles; output holds last valid result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_v <= 1'b0; p1_v <= 1'b0; e_v <= 1'b0;
         p0_re <= 0; p0_im <= 0; p1_re <= 0; p1_im <= 0; e_re <= 0; e_im <= 0;
         for (int k = 0; k < 4; k++) begin
            sh_re[k] <= 0; sh_im[k] <= 0; act_re[k] <= 0; act_im[k] <= 0;
         end
      end else begin
         p0_v <= bus.in_valid;
         if (bus.in_valid) begin
            p0_re <= lut_sum(bus.sel, act_re);
            p0_im <= lut_sum(bus.sel, act_im);
         end
         p1_v <= p0_v; p1_re <= p0_re; p1_im <= p0_im;
         e_v <= p1_v;
         if (p1_v) begin
            e_re <= p1_re; e_im <= p1_im;
         end
         if (bus.cfg_commit) begin
            for (int k = 0; k < 4; k++) begin
               act_re[k] <= sh_re[k]; act_im[k] <= sh_im[k];
            end
         end
         if (bus.cfg_we && (int'(bus.cfg_addr) < M)) begin
            sh_re[bus.cfg_addr] <= int'(bus.cfg_re);
            sh_im[bus.cfg_addr] <= int'(bus.cfg_im);
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      chk("out_valid", int'(bus.out_valid), int'(e_v));
      chk("out_re", int'(bus.out_re), e_re);
      chk("out_im", int'(bus.out_im), e_im);
   end

   // Literal expectations checked against both the model and the DUT.
   task automatic pin(input string nm, input int er, input int ei);
      chk({nm, "_model_v"},  int'(e_v), 1);
      chk({nm, "_model_re"}, e_re, er);
      chk({nm, "_model_im"}, e_im, ei);
      chk({nm, "_dut_v"},    int'(bus.out_valid), 1);
      chk({nm, "_dut_re"},   int'(bus.out_re), er);
      chk({nm, "_dut_im"},   int'(bus.out_im), ei);
   endtask

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input int a, input int re, input int im, input logic cm);
      bus.cfg_we     = 1'b1;
      bus.cfg_addr   = 2'(a);
      bus.cfg_re     = 16'(re);
      bus.cfg_im     = 16'(im);
      bus.cfg_commit = cm;
      tick();
      bus.cfg_we     = 1'b0;
      bus.cfg_commit = 1'b0;
   endtask

   task automatic commit();
      bus.cfg_commit = 1'b1;
      tick();
      bus.cfg_commit = 1'b0;
   endtask

   task automatic send(input logic [3:0] s);
      bus.in_valid = 1'b1;
      bus.sel      = s;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic run_pin(input string nm, input logic [3:0] s, input int er, input int ei);
      send(s);
      tick();
      tick();
      pin(nm, er, ei);
   endtask

   logic [3:0] st_sel [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   int         st_re  [4] = '{5120, -3072, -11264, -13312};
   int         st_im  [4] = '{1024, -7168, 5120, 3072};

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0; bus.sel = 4'b0000; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0;
      bus.cfg_re = 16'sd0; bus.cfg_im = 16'sd0; bus.cfg_commit = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("idle_valid", int'(bus.out_valid), 0);
      chk("idle_re", int'(bus.out_re), 0);
      chk("idle_im", int'(bus.out_im), 0);

      wr(0, 8192, 0, 1'b0);
      wr(1, 4096, -4096, 1'b0);
      wr(2, 0, 2048, 1'b0);
      wr(3, -1024, 1024, 1'b0);
      commit();
      run_pin("all_pos", 4'b1111, 11264, -1024);
      run_pin("all_neg", 4'b0000, -11264, 1024);

      fork
         begin
            for (int i = 0; i < 4; i++) send(st_sel[i]);
         end
         begin
            repeat (3) tick();
            for (int i = 0; i < 4; i++) begin
               pin($sformatf("stream%0d", i), st_re[i], st_im[i]);
               tick();
            end
         end
      join
      repeat (2) tick();

      // Shadow write without commit leaves the data path alone.
      wr(0, -8192, 0, 1'b0);
      run_pin("shadow_iso", 4'b1111, 11264, -1024);

      // Commit together with a sample: that sample sees the old bank.
      bus.cfg_commit = 1'b1;
      bus.in_valid   = 1'b1;
      bus.sel        = 4'b1111;
      tick();
      bus.cfg_commit = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      pin("commit_old", 11264, -1024);
      tick();
      pin("commit_new", -5120, -1024);

      // Write and commit in the same cycle: commit takes pre-write shadow.
      wr(1, 0, 0, 1'b1);
      run_pin("collide", 4'b1111, -5120, -1024);
      commit();
      run_pin("recommit", 4'b1111, -9216, 3072);
      commit();
      commit();
      run_pin("repeat_commit", 4'b1111, -9216, 3072);

      // Most negative coefficients: negation must not wrap.
      for (int a = 0; a < 4; a++) wr(a, -32768, -32768, 1'b0);
      commit();
      run_pin("extreme_neg", 4'b0000, 131072, 131072);
      run_pin("extreme_pos", 4'b1111, -131072, -131072);

      // Reset in the middle of a stream.
      bus.in_valid = 1'b1;
      bus.sel      = 4'b0000;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_valid", int'(bus.out_valid), 0);
      chk("rst_async_re", int'(bus.out_re), 0);
      chk("rst_async_im", int'(bus.out_im), 0);
      bus.in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      run_pin("post_rst_neg", 4'b0000, 0, 0);
      run_pin("post_rst_pos", 4'b1111, 0, 0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
